conv2d_stream: RTL and testbench

Parametrised 3x3 image convolution engine; successor to the fixed-size `conv2d`. Scans a row-major source image in an external combinationally-read memory, forms a 3x3 window from two internal line buffers, and applies one of four selectable kernels. Writes the (IMG_W-2)x(IMG_H-2) valid-region result to an external write port. Sits between the input frame memory and the output frame memory, under a start/ready handshake from the top-level controller.

---
 rtl/conv2d_stream.sv | 177 +++++++++++++++++
 tb/tb_conv2d_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 convolution over a row-major frame read from an
// external combinational memory. Two line buffers plus a 3x3 shift window feed a
// registered kernel stage (pass / Gaussian / Laplacian / sharpen). Only windows
// with a full 3x3 neighbourhood produce writes, so the output frame is
// (IMG_W-2) x (IMG_H-2), written with a gap-free row-major address.
module conv2d_stream #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 50,
    parameter int IMG_H  = 50,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] d_in,
    output logic [ADDR_W-1:0] ReadAddress,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] d_out,
    output logic              we,
    output logic              ready,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 4;
    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [DATA_W-1:0]        PIX_MAX   = {DATA_W{1'b1}};
    localparam logic signed [SW-1:0]     MAXV      = SW'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH1,
        S_FLUSH2,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic              accept;
    logic [1:0]        kmode;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              cap_valid;
    logic [ADDR_W-1:0] wr_count;
    logic [DATA_W-1:0] win [3][3];
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic signed [SW-1:0] p_c, p_n, p_s, p_e, p_w, neigh, lap, lap_abs, sharp;
    logic [SW-1:0]        gsum;
    logic [DATA_W-1:0]    result;

    // Frame sequencing state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next state and handshake outputs; DONE also reports ready so a new frame can chain directly.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = S_RUN;
            end
            S_RUN:    if (ReadAddress == LAST_ADDR) state_next = S_FLUSH1;
            S_FLUSH1: state_next = S_FLUSH2;
            S_FLUSH2: state_next = S_DONE;
            S_DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? S_RUN : S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    assign accept = start && ready;

    // Source scan: read address plus the row/column of the pixel being read; kernel latched at start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ReadAddress <= '0;
            row         <= '0;
            col         <= '0;
            kmode       <= '0;
        end else if (accept) begin
            ReadAddress <= '0;
            row         <= '0;
            col         <= '0;
            kmode       <= mode;
        end else if (state == S_RUN && ReadAddress != LAST_ADDR) begin
            ReadAddress <= ReadAddress + 1'b1;
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Marks that the window just captured has a full neighbourhood (no wrap columns/rows).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cap_valid <= 1'b0;
        else      cap_valid <= (state == S_RUN) && (row >= RW'(2)) && (col >= CW'(2));
    end

    // Window shift and line buffers; contents are meaningless until cap_valid qualifies them.
    always_ff @(posedge clk) begin
        if (state == S_RUN) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb0[col];
            win[1][2] <= lb1[col];
            win[2][2] <= d_in;
            lb0[col]  <= lb1[col];
            lb1[col]  <= d_in;
        end
    end

    // Kernel arithmetic on the current window, widened so no intermediate can overflow.
    always_comb begin
        p_c   = $signed(SW'(win[1][1]));
        p_n   = $signed(SW'(win[0][1]));
        p_s   = $signed(SW'(win[2][1]));
        p_w   = $signed(SW'(win[1][0]));
        p_e   = $signed(SW'(win[1][2]));
        neigh = p_n + p_s + p_e + p_w;
        lap   = (p_c <<< 2) - neigh;
        sharp = (p_c <<< 2) + p_c - neigh;
        lap_abs = lap[SW-1] ? -lap : lap;
        gsum  = SW'(win[0][0]) + SW'(win[0][2]) + SW'(win[2][0]) + SW'(win[2][2])
              + ((SW'(win[0][1]) + SW'(win[1][0]) + SW'(win[1][2]) + SW'(win[2][1])) << 1)
              + (SW'(win[1][1]) << 2);
        result = win[1][1];
        case (kmode)
            2'd0: result = win[1][1];
            2'd1: result = gsum[SW-1:4];
            2'd2: result = (lap_abs > MAXV) ? PIX_MAX : lap_abs[DATA_W-1:0];
            2'd3: begin
                if (sharp[SW-1])       result = '0;
                else if (sharp > MAXV) result = PIX_MAX;
                else                   result = sharp[DATA_W-1:0];
            end
            default: result = win[1][1];
        endcase
    end

    // Output register stage: one write per qualified window, addresses strictly sequential.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out        <= '0;
            we           <= 1'b0;
            WriteAddress <= '0;
            wr_count     <= '0;
        end else begin
            we <= cap_valid;
            if (accept) begin
                wr_count <= '0;
            end else if (cap_valid) begin
                d_out        <= result;
                WriteAddress <= wr_count;
                wr_count     <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Testbench for conv2d_stream: a 4x4 instance for directed and random kernel
// frames, and a default 50x50 instance for a full random frame, mid-frame start
// and mode noise, and an asynchronous reset in the middle of a frame.
module tb_conv2d_stream;

    localparam int DW = 12;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 50;
    localparam int LH = 50;

    logic clk = 1'b0;
    logic rst;

    logic          start_a, we_a, ready_a, done_a;
    logic [1:0]    mode_a;
    logic [DW-1:0] d_in_a, d_out_a;
    logic [3:0]    ra_a, wa_a;
    logic [DW-1:0] mem_a [SW*SH];

    logic          start_b, we_b, ready_b, done_b;
    logic [1:0]    mode_b;
    logic [DW-1:0] d_in_b, d_out_b;
    logic [16:0]   ra_b, wa_b;
    logic [DW-1:0] mem_b [LW*LH];

    int model_img [LW*LH];
    int model_w;
    int qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    assign d_in_a = mem_a[ra_a];
    assign d_in_b = (ra_b < 17'(LW*LH)) ? mem_b[ra_b[11:0]] : '0;

    conv2d_stream #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SH), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .d_in(d_in_a),
        .ReadAddress(ra_a), .WriteAddress(wa_a), .d_out(d_out_a),
        .we(we_a), .ready(ready_a), .done(done_a)
    );

    conv2d_stream dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .d_in(d_in_b),
        .ReadAddress(ra_b), .WriteAddress(wa_b), .d_out(d_out_b),
        .we(we_b), .ready(ready_b), .done(done_b)
    );

    // Collect every write strobe of both instances, sampled away from the rising edge.
    always @(negedge clk) begin
        if (we_a) begin
            qa_addr.push_back(int'(wa_a));
            qa_data.push_back(int'(d_out_a));
        end
        if (we_b) begin
            qb_addr.push_back(int'(wa_b));
            qb_data.push_back(int'(d_out_b));
        end
    end

    // Reference kernel evaluated directly on the image around centre (r,c).
    function automatic int ref_px(input int mode, input int r, input int c);
        int p [3][3];
        int v;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                p[dr][dc] = model_img[(r + dr - 1) * model_w + (c + dc - 1)];
        case (mode)
            0: v = p[1][1];
            1: v = (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
                    + p[2][0] + 2*p[2][1] + p[2][2]) / 16;
            2: begin
                v = 4*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
                if (v < 0) v = -v;
                if (v > 4095) v = 4095;
            end
            default: begin
                v = 5*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
                if (v < 0) v = 0;
                if (v > 4095) v = 4095;
            end
        endcase
        return v;
    endfunction

    task automatic frame_a(input logic [1:0] m, output int done_cyc, output logic rdy_at_done);
        done_cyc = -1;
        rdy_at_done = 1'b0;
        qa_addr.delete();
        qa_data.delete();
        for (int i = 0; i < 50 && !ready_a; i++) @(negedge clk);
        start_a = 1'b1;
        mode_a  = m;
        @(posedge clk);
        for (int cyc = 1; cyc <= SW*SH + 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_a = 1'b0;
                mode_a  = ~m;
            end
            if (done_a) begin
                done_cyc = cyc;
                rdy_at_done = ready_a;
                return;
            end
        end
    endtask

    task automatic frame_b(input logic [1:0] m, input int glitch_at, input int reset_at,
                           output int done_cyc);
        done_cyc = -1;
        qb_addr.delete();
        qb_data.delete();
        for (int i = 0; i < 50 && !ready_b; i++) @(negedge clk);
        start_b = 1'b1;
        mode_b  = m;
        @(posedge clk);
        for (int cyc = 1; cyc <= LW*LH + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_b = 1'b0;
                mode_b  = ~m;
            end
            if (cyc == glitch_at) begin
                start_b = 1'b1;
                mode_b  = m + 2'd1;
            end
            if (cyc == glitch_at + 1) start_b = 1'b0;
            if (cyc == reset_at) begin
                #2 rst = 1'b0;
                #1;
                return;
            end
            if (done_b) begin
                done_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_a = 1'b0; mode_a = 2'd0;
        start_b = 1'b0; mode_b = 2'd0;
        #12;
        n_cmp++;
        if (ra_b !== 17'd0 || wa_b !== 17'd0 || d_out_b !== 12'd0 || we_b !== 1'b0 || done_b !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs_b: ra=%0d wa=%0d d_out=%0d we=%0d done=%0d required all 0",
                     ra_b, wa_b, d_out_b, we_b, done_b);
        end
        n_cmp++;
        if (ra_a !== 4'd0 || wa_a !== 4'd0 || d_out_a !== 12'd0 || we_a !== 1'b0 || done_a !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs_a: ra=%0d wa=%0d d_out=%0d we=%0d done=%0d required all 0",
                     ra_a, wa_a, d_out_a, we_a, done_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: ready_a=%0d ready_b=%0d required 1", ready_a, ready_b);
        end
    endtask

    task automatic test_kernels_small();
        int pat_tab [11]  = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 3};
        int mode_tab [11] = '{0, 1, 2, 3, 2, 3, 3, 1, 2, -1, -1};
        int ramp_exp [4]  = '{5, 6, 9, 10};
        int m, dc, exp_v;
        logic rdy;
        model_w = SW;
        for (int k = 0; k < 11; k++) begin
            m = (mode_tab[k] < 0) ? int'($urandom_range(0, 3)) : mode_tab[k];
            for (int i = 0; i < SW*SH; i++) begin
                case (pat_tab[k])
                    0: mem_a[i] = DW'(i);
                    1: mem_a[i] = (i == 5) ? 12'd100 : 12'd0;
                    2: mem_a[i] = 12'd4095;
                    default: mem_a[i] = DW'($urandom_range(0, 4095));
                endcase
                model_img[i] = int'(mem_a[i]);
            end
            frame_a(2'(m), dc, rdy);
            n_cmp++;
            if (dc != SW*SH + 3 || rdy !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL small_done k=%0d: done at cycle %0d ready=%0d, required cycle %0d ready=1",
                         k, dc, rdy, SW*SH + 3);
            end
            n_cmp++;
            if (qa_addr.size() != 4) begin
                n_bad++;
                $display("[TB] FAIL small_write_count k=%0d: got %0d writes, required 4", k, qa_addr.size());
            end
            for (int i = 0; i < 4 && i < qa_addr.size(); i++) begin
                exp_v = ref_px(m, 1 + i / 2, 1 + i % 2);
                n_cmp++;
                if (qa_addr[i] != i || qa_data[i] != exp_v) begin
                    n_bad++;
                    $display("[TB] FAIL small_write k=%0d mode=%0d idx=%0d: got (%0d,%0d) required (%0d,%0d)",
                             k, m, i, qa_addr[i], qa_data[i], i, exp_v);
                end
                if (pat_tab[k] == 0 && m != 2) begin
                    n_cmp++;
                    if (qa_data[i] != ramp_exp[i]) begin
                        n_bad++;
                        $display("[TB] FAIL ramp_const mode=%0d idx=%0d: got %0d required %0d",
                                 m, i, qa_data[i], ramp_exp[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_large_frame();
        int dc, exp_v;
        model_w = LW;
        for (int i = 0; i < LW*LH; i++) begin
            mem_b[i] = DW'($urandom_range(0, 4095));
            model_img[i] = int'(mem_b[i]);
        end
        frame_b(2'd1, 100, 0, dc);
        n_cmp++;
        if (dc != LW*LH + 3) begin
            n_bad++;
            $display("[TB] FAIL large_done: done at cycle %0d, required %0d", dc, LW*LH + 3);
        end
        n_cmp++;
        if (qb_addr.size() != (LW-2)*(LH-2)) begin
            n_bad++;
            $display("[TB] FAIL large_write_count: got %0d, required %0d", qb_addr.size(), (LW-2)*(LH-2));
        end
        for (int i = 0; i < qb_addr.size() && i < (LW-2)*(LH-2); i++) begin
            exp_v = ref_px(1, 1 + i / (LW-2), 1 + i % (LW-2));
            n_cmp++;
            if (qb_addr[i] != i || qb_data[i] != exp_v) begin
                n_bad++;
                $display("[TB] FAIL large_write idx=%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, qb_addr[i], qb_data[i], i, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int dc, exp_v, m;
        frame_b(2'd0, 0, 700, dc);
        n_cmp++;
        if (ra_b !== 17'd0 || wa_b !== 17'd0 || d_out_b !== 12'd0 || we_b !== 1'b0 ||
            done_b !== 1'b0 || ready_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL midframe_reset: ra=%0d wa=%0d d_out=%0d we=%0d done=%0d ready=%0d required 0,0,0,0,0,1",
                     ra_b, wa_b, d_out_b, we_b, done_b, ready_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        qb_addr.delete();
        qb_data.delete();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (qb_addr.size() != 0 || ready_b !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL after_reset_idle: writes=%0d ready=%0d required 0 writes ready=1",
                     qb_addr.size(), ready_b);
        end
        m = int'($urandom_range(0, 3));
        model_w = LW;
        for (int i = 0; i < LW*LH; i++) begin
            mem_b[i] = DW'($urandom_range(0, 4095));
            model_img[i] = int'(mem_b[i]);
        end
        frame_b(2'(m), 0, 0, dc);
        n_cmp++;
        if (dc != LW*LH + 3 || qb_addr.size() != (LW-2)*(LH-2)) begin
            n_bad++;
            $display("[TB] FAIL rerun_frame: done at %0d with %0d writes, required %0d with %0d",
                     dc, qb_addr.size(), LW*LH + 3, (LW-2)*(LH-2));
        end
        for (int i = 0; i < qb_addr.size() && i < (LW-2)*(LH-2); i++) begin
            exp_v = ref_px(m, 1 + i / (LW-2), 1 + i % (LW-2));
            n_cmp++;
            if (qb_addr[i] != i || qb_data[i] != exp_v) begin
                n_bad++;
                $display("[TB] FAIL rerun_write mode=%0d idx=%0d: got (%0d,%0d) required (%0d,%0d)",
                         m, i, qb_addr[i], qb_data[i], i, exp_v);
            end
        end
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_kernels_small();
        test_large_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
